// File: rtl/seq_divider.sv
// Multi-cycle 32-bit unsigned restoring divider producing one quotient bit per cycle.
// The trial subtraction each cycle is performed by a single yArith unit held in subtract mode.

module yArith (
  output logic [31:0] z,
  output logic        cout,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        ctrl
);
  logic [31:0] b_x;
  logic [32:0] sum;

  // ctrl=1 gives a - b as a + ~b + 1; cout=1 then means a >= b.
  always_comb begin
    b_x = b ^ {32{ctrl}};
    sum = {1'b0, a} + {1'b0, b_x} + {32'd0, ctrl};
  end

  assign z    = sum[31:0];
  assign cout = sum[32];
endmodule

module seq_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             dbz
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state_q;
  logic [WIDTH-1:0] d_q, q_q, r_q, quot_q, rem_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q, done_q, dbz_q;

  logic [WIDTH-1:0] s_w, z_w, r_d, q_d;
  logic             cout_w, take_w;

  // A set R[MSB] means the shifted value exceeds 2^WIDTH > D, so the subtract always succeeds.
  always_comb begin
    s_w    = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
    take_w = r_q[WIDTH-1] | cout_w;
    r_d    = take_w ? z_w : s_w;
    q_d    = {q_q[WIDTH-2:0], take_w};
  end

  yArith u_sub (
    .z    (z_w),
    .cout (cout_w),
    .a    (s_w),
    .b    (d_q),
    .ctrl (1'b1)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      d_q     <= '0;
      q_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          // A start coinciding with the done pulse is dropped.
          if (start && !done_q) begin
            d_q   <= divisor;
            q_q   <= dividend;
            r_q   <= '0;
            cnt_q <= '0;
            if (divisor == '0) begin
              quot_q  <= '1;
              rem_q   <= dividend;
              dbz_q   <= 1'b1;
              state_q <= DONE;
            end else begin
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          busy_q <= 1'b1;
          r_q    <= r_d;
          q_q    <= q_d;
          cnt_q  <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST) begin
            quot_q  <= q_d;
            rem_q   <= r_d;
            dbz_q   <= 1'b0;
            state_q <= DONE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign dbz       = dbz_q;
endmodule
